// File: rtl/fase_sync_ctrl_pkg.sv
// fase_sync_ctrl_pkg: shared constants and FSM encoding for the FIR phase-search path
//   OS          oversampling factor of the FIR output stream
//   NB_FASE     width of the phase select
//   NB_DATA_DEF sample width shared with the FIR and the phase-shifter
package fase_sync_ctrl_pkg;

    localparam int OS          = 4;
    localparam int NB_FASE     = 2;
    localparam int NB_DATA_DEF = 8;

    typedef enum logic [2:0] {IDLE, ALIGN, ACCUM, COMPARE, LOCK} state_t;

    function automatic logic is_busy(input state_t s);
        return s == ALIGN || s == ACCUM || s == COMPARE;
    endfunction

endpackage

// File: rtl/fase_sync_ctrl_if.sv
// fase_sync_ctrl_if: sample stream and phase-select bundle of the phase-search controller
//   i_enable/i_data        FIR output sample stream
//   i_start/i_manual/i_fase_manual  search control and manual override
//   o_fase/o_valid         phase select and symbol strobe to the phase-shifter/slicer
//   o_locked/o_busy/o_energy  search status
//   master: drives the sample stream and control; slave: the controller
interface fase_sync_ctrl_if import fase_sync_ctrl_pkg::*; #(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_ACC  = NB_DATA_DEF + 10
);
    logic                      i_enable;
    logic signed [NB_DATA-1:0] i_data;
    logic                      i_start;
    logic                      i_manual;
    logic [NB_FASE-1:0]        i_fase_manual;
    logic [NB_FASE-1:0]        o_fase;
    logic                      o_valid;
    logic                      o_locked;
    logic                      o_busy;
    logic [NB_ACC-1:0]         o_energy;

    modport master (
        output i_enable, i_data, i_start, i_manual, i_fase_manual,
        input  o_fase, o_valid, o_locked, o_busy, o_energy
    );

    modport slave (
        input  i_enable, i_data, i_start, i_manual, i_fase_manual,
        output o_fase, o_valid, o_locked, o_busy, o_energy
    );

endinterface

// File: rtl/fase_sync_ctrl_phase_energy_acc.sv
// phase_energy_acc: per-phase |sample| accumulators
//   clock, i_reset  clock and synchronous active-high reset
//   i_enable        qualifies every update
//   i_clear         zero all accumulators (wins over i_add)
//   i_add, i_idx    add |i_data| into accumulator i_idx
//   i_data          signed sample
//   o_acc           the OS accumulators
module phase_energy_acc import fase_sync_ctrl_pkg::*; #(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_ACC  = NB_DATA_DEF + 10
) (
    input  logic                           clock,
    input  logic                           i_reset,
    input  logic                           i_enable,
    input  logic                           i_clear,
    input  logic                           i_add,
    input  logic [NB_FASE-1:0]             i_idx,
    input  logic signed [NB_DATA-1:0]      i_data,
    output logic [OS-1:0][NB_ACC-1:0]      o_acc
);

    logic [NB_DATA-1:0]          mag;
    logic [OS-1:0][NB_ACC-1:0]   acc_q, acc_d;

    // unsigned magnitude on NB_DATA bits, so the most negative value maps to 2^(NB_DATA-1)
    assign mag = i_data[NB_DATA-1] ? $unsigned(-i_data) : $unsigned(i_data);

    always_comb begin
        acc_d = acc_q;
        if (i_clear)
            acc_d = '0;
        else if (i_add)
            acc_d[i_idx] = acc_q[i_idx] + NB_ACC'(mag);
    end

    always_ff @(posedge clock)
        if (i_reset)
            acc_q <= '0;
        else if (i_enable)
            acc_q <= acc_d;

    assign o_acc = acc_q;

endmodule

// File: rtl/fase_sync_ctrl.sv
// fase_sync_ctrl: phase search over a symbol window and symbol-rate decimation strobe
//   clock, i_reset  clock and synchronous active-high reset
//   bus (slave)     sample stream in, phase select / strobe / search status out
//   NB_DATA         sample width; N_SYM_LOG2 log2 of window length in symbols
//   NB_ACC          accumulator width, wide enough for the full window
module fase_sync_ctrl import fase_sync_ctrl_pkg::*; #(
    parameter int NB_DATA    = NB_DATA_DEF,
    parameter int N_SYM_LOG2 = 10,
    parameter int NB_ACC     = NB_DATA + N_SYM_LOG2
) (
    input  logic             clock,
    input  logic             i_reset,
    fase_sync_ctrl_if.slave  bus
);

    state_t                     state_q, state_d;
    logic [1:0]                 cnt_q;
    logic [N_SYM_LOG2-1:0]      sym_q, sym_d;
    logic [NB_FASE-1:0]         idx_q, idx_d;
    logic [NB_FASE-1:0]         best_q, best_d;
    logic [NB_FASE-1:0]         fase_q, fase_d;
    logic [NB_ACC-1:0]          energy_q, energy_d;
    logic                       valid_q;
    logic [OS-1:0][NB_ACC-1:0]  acc;
    logic                       en, start, sym_last, clear, add;

    assign en       = bus.i_enable;
    assign start    = bus.i_start;
    assign sym_last = cnt_q == 2'd3 && &sym_q;

    phase_energy_acc #(.NB_DATA(NB_DATA), .NB_ACC(NB_ACC)) u_acc (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_enable (en),
        .i_clear  (clear),
        .i_add    (add),
        .i_idx    (cnt_q),
        .i_data   (bus.i_data),
        .o_acc    (acc)
    );

    always_ff @(posedge clock)
        if (i_reset)
            state_q <= IDLE;
        else if (en)
            state_q <= state_d;

    // i_start restarts the search from any state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? ALIGN : IDLE;
            ALIGN:   state_d = start ? ALIGN : (cnt_q == 2'd0 ? ACCUM : ALIGN);
            ACCUM:   state_d = start ? ALIGN : (sym_last ? COMPARE : ACCUM);
            COMPARE: state_d = start ? ALIGN : (idx_q == 2'd3 ? LOCK : COMPARE);
            LOCK:    state_d = start ? ALIGN : LOCK;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.o_busy   = is_busy(state_q);
        bus.o_locked = state_q == LOCK;
        bus.o_valid  = valid_q & en;
        bus.o_fase   = fase_q;
        bus.o_energy = energy_q;
    end

    // ALIGN consumes the phase-0 sample on its way out, so the window starts on a symbol boundary
    always_comb begin
        clear    = state_d == ALIGN;
        add      = !start && ((state_q == ALIGN && cnt_q == 2'd0) || state_q == ACCUM);
        sym_d    = clear ? '0 : (state_q == ACCUM && cnt_q == 2'd3 ? sym_q + N_SYM_LOG2'(1) : sym_q);
        idx_d    = state_q == COMPARE ? idx_q + 2'd1 : '0;
        best_d   = state_q == COMPARE ? (acc[idx_q] > acc[best_q] ? idx_q : best_q)
                 : state_q == LOCK    ? best_q : '0;
        fase_d   = bus.i_manual ? bus.i_fase_manual : (state_d == LOCK ? best_d : fase_q);
        energy_d = state_d == LOCK ? acc[best_d] : energy_q;
    end

    always_ff @(posedge clock)
        if (i_reset) begin
            cnt_q    <= '0;
            sym_q    <= '0;
            idx_q    <= '0;
            best_q   <= '0;
            fase_q   <= '0;
            energy_q <= '0;
            valid_q  <= 1'b0;
        end else if (en) begin
            cnt_q    <= cnt_q + 2'd1;
            sym_q    <= sym_d;
            idx_q    <= idx_d;
            best_q   <= best_d;
            fase_q   <= fase_d;
            energy_q <= energy_d;
            valid_q  <= cnt_q == 2'd3;
        end

endmodule

// File: doc/fase_sync_ctrl.md
Name: fase_sync_ctrl

Overview:
Phase-search and decimation controller for the TX/RX FIR polyphase output path.
- Tracks the oversampling position of the FIR output stream (OS = 4).
- Over a window of symbols, accumulates |sample| per phase and selects the phase with maximum energy.
- Drives the 2-bit phase select and the symbol-rate valid strobe of the downstream phase-shifter/slicer.
- Supports a manual phase override.

Parameters:
NB_DATA, 8, width of the signed FIR output sample.
N_SYM_LOG2, 10, log2 of the number of symbols in the search window.
NB_ACC, NB_DATA+N_SYM_LOG2, accumulator width. Exact worst case is 128·2^N_SYM_LOG2, so no overflow is possible.

Ports:
clock  in  1  system clock
i_reset  in  1  synchronous reset, active-high
i_enable  in  1  sample enable; one FIR output sample per enabled cycle
i_data  in  NB_DATA  signed FIR output sample
i_start  in  1  start/restart a phase search (level sampled when i_enable=1)
i_manual  in  1  1 = o_fase follows i_fase_manual, search result ignored
i_fase_manual  in  2  manual phase value
o_fase  out  2  phase select for downstream phase-shifter
o_valid  out  1  symbol strobe, one cycle per 4 enabled samples
o_locked  out  1  search complete, o_fase holds the search result
o_busy  out  1  search in progress (ALIGN/ACCUM/COMPARE)
o_energy  out  NB_ACC  accumulated energy of the selected phase

Behaviour:
- Reset (synchronous, active-high; clock clock):
  - State IDLE; sample counter cnt = 0; symbol counter = 0; all 4 accumulators = 0.
  - o_fase = 0, o_valid = 0, o_locked = 0, o_busy = 0, o_energy = 0.
  - Reset mid-search aborts the search with no residual state.
- Gating:
  - Every register update except reset is qualified by i_enable.
  - With i_enable = 0 the block is fully frozen: o_valid = 0, and the COMPARE index does not advance.
- Sample counter:
  - cnt (2 bits) increments per enabled cycle and wraps 3 -> 0.
  - The sample taken when cnt == k belongs to phase k.
  - o_valid is a registered pulse: high in the enabled cycle after cnt == 3 was consumed, low otherwise.
- Magnitude:
  - |x| is computed unsigned on NB_DATA bits, so |-128| = 128.
  - Accumulator add is unsigned with zero extension to NB_ACC.
- FSM:
  - IDLE: i_start -> ALIGN.
  - ALIGN: accumulators and symbol counter are cleared on entry. Waits for an enabled cycle with cnt == 0, then accumulates that sample into acc[0] and goes to ACCUM.
  - ACCUM: acc[cnt] += |i_data| each enabled cycle. Consuming the cnt == 3 sample increments the symbol counter. When the 2^N_SYM_LOG2-th symbol completes -> COMPARE.
  - COMPARE: sequential scan over index 0..3, one index per enabled cycle (4 cycles). best is updated on strictly greater, so ties resolve to the lowest phase. After index 3 -> LOCK.
  - LOCK: o_fase = best (when i_manual = 0); o_energy = acc[best]; o_locked = 1. Remains until i_start.
- Restart:
  - i_start in any non-IDLE state goes to ALIGN next enabled cycle and clears accumulators.
  - o_locked drops the same cycle ALIGN is entered.
  - o_fase keeps its previous value until the new LOCK.
  - i_start held high in ALIGN/ACCUM keeps re-clearing, so the search begins after i_start deasserts.
- Outputs:
  - o_busy = 1 in ALIGN/ACCUM/COMPARE.
  - Latency: the last window sample is consumed at cycle T; o_locked = 1 and o_fase update at T+5 enabled cycles.
- Manual override:
  - i_manual = 1: o_fase <= i_fase_manual registered, 1-cycle latency, independent of FSM state.
  - The search still runs; o_locked reflects the search only.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, ALIGN, ACCUM, COMPARE, LOCK).
  - OS = 4 and the phase-select width of 2.
  - NB_DATA default shared with the FIR and phase-shifter.
- Sub-module phase_energy_acc: 4 × NB_ACC accumulators with abs, clear, and add-at-index.
- FSM, counters and compare stay in the top.

Test Plan:
- Setup for all scenarios: N_SYM_LOG2 = 2 (4-symbol window), i_enable = 1.
- Phase selection: phase 2 samples alternating +100/-100, other phases ±10; pulse i_start -> o_fase = 2, o_energy = 400, o_locked = 1, o_busy = 0.
- Tie and extreme value: all phases ±50 -> o_fase = 0, o_energy = 200. Then phase 1 = -128, others 0 -> o_fase = 1, o_energy = 512.
- Enable gaps: i_enable toggled 1/0 every cycle during the scenario 1 stimulus -> same result. o_valid pulses exactly once per 4 enabled samples, never while i_enable = 0.
- Reset mid-ACCUM: i_reset after 2 symbols -> all outputs 0 next cycle, state IDLE. A new i_start gives a correct result that ignores pre-reset data.
- Restart and manual override:
  - After lock on phase 2, i_start with phase 3 dominant -> o_locked drops, o_fase stays 2 until re-lock, then becomes 3.
  - i_manual = 1, i_fase_manual = 1 -> o_fase = 1 one cycle later, with o_locked unaffected.
